// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH independent clocked SR flip-flops with a selectable
// S=R=1 response, global update enable, per-channel change pulses, a registered
// conflict flag and a sticky conflict error with clear.
// Optional feature macro: SR_CONFLICT_CNT_EN adds a saturating conflict_cnt
// output counting edges on which any channel saw S=R=1.
module sr_ff_bank #(
  parameter int               WIDTH         = 4,
  parameter int               CONFLICT_MODE = 0,   // 0 hold, 1 set-dom, 2 reset-dom, 3 toggle
  parameter logic [WIDTH-1:0] INIT          = '0,
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic             conflict,
  output logic             err_sticky
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Reject configurations that cannot be built meaningfully.
  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: CONFLICT_MODE must be in 0..3");
  end
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
    $error("sr_ff_bank: WIDTH and CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] qb_reg;
  logic [WIDTH-1:0] chg_reg, chg_next;
  logic [WIDTH-1:0] conf_val;
  logic             conflict_reg, conflict_next;
  logic             err_sticky_reg, err_sticky_next;

  // Value a channel takes when both s and r are asserted, chosen at elaboration.
  case (CONFLICT_MODE)
    0:       begin : g_mode_hold  assign conf_val = q_reg;  end
    1:       begin : g_mode_set   assign conf_val = '1;     end
    2:       begin : g_mode_reset assign conf_val = '0;     end
    default: begin : g_mode_tog   assign conf_val = ~q_reg; end
  endcase

  // Per-channel SR decode; channels never look at each other's inputs or state.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    assign q_next[gi] = !en                ? q_reg[gi]    :
                        (s[gi] && r[gi])   ? conf_val[gi] :
                        s[gi]              ? 1'b1         :
                        r[gi]              ? 1'b0         :
                                             q_reg[gi];
  end

  // A disabled edge leaves q untouched, so chg falls to zero without special casing.
  assign chg_next        = q_next ^ q_reg;
  assign conflict_next   = en & (|(s & r));
  // A new conflict wins over a simultaneous clear so no event is ever lost.
  assign err_sticky_next = (err_sticky_reg & ~err_clr) | conflict_next;

  // State register: async reset to INIT, otherwise one-cycle update of all flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg          <= INIT;
      qb_reg         <= ~INIT;
      chg_reg        <= '0;
      conflict_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      q_reg          <= q_next;
      qb_reg         <= ~q_next;
      chg_reg        <= chg_next;
      conflict_reg   <= conflict_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign q          = q_reg;
  assign qb         = qb_reg;
  assign chg        = chg_reg;
  assign conflict   = conflict_reg;
  assign err_sticky = err_sticky_reg;

`ifdef SR_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Saturating count of conflict edges; a clear coinciding with a conflict restarts at 1.
  always_comb begin
    cnt_next = cnt_reg;
    if (err_clr) begin
      cnt_next = conflict_next ? CNT_W'(1) : '0;
    end else if (conflict_next && cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign conflict_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: drives four sr_ff_bank instances (one per CONFLICT_MODE) with the
// same stimulus. Each driven edge pushes the model's prediction to a scoreboard
// queue that a monitor pops and compares after the edge; feature tasks add
// literal spot checks for the documented scenarios.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       err_clr = 1'b0;

  logic [3:0] q_o        [4];
  logic [3:0] qb_o       [4];
  logic [3:0] chg_o      [4];
  logic       conflict_o [4];
  logic       sticky_o   [4];
`ifdef SR_CONFLICT_CNT_EN
  logic [1:0] cnt_o      [4];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sr_ff_bank #(
      .WIDTH(4), .CONFLICT_MODE(gi), .INIT(4'b0000), .CNT_W(2)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .err_clr(err_clr),
      .q(q_o[gi]), .qb(qb_o[gi]), .chg(chg_o[gi]),
      .conflict(conflict_o[gi]), .err_sticky(sticky_o[gi])
`ifdef SR_CONFLICT_CNT_EN
      , .conflict_cnt(cnt_o[gi])
`endif
    );
  end

  typedef struct packed {
    logic [3:0][3:0] q;
    logic [3:0][3:0] chg;
    logic            conflict;
    logic            sticky;
    logic [1:0]      cnt;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [3:0] mq [4];
  logic       msticky;
  logic [1:0] mcnt;

  function automatic logic [3:0] model_next(int mode, logic [3:0] cur,
                                            logic [3:0] sv, logic [3:0] rv, logic e);
    logic [3:0] n;
    n = cur;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (sv[i] && !rv[i])      n[i] = 1'b1;
        else if (!sv[i] && rv[i]) n[i] = 1'b0;
        else if (sv[i] && rv[i]) begin
          case (mode)
            1:       n[i] = 1'b1;
            2:       n[i] = 1'b0;
            3:       n[i] = ~cur[i];
            default: n[i] = cur[i];
          endcase
        end
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) mq[m] = 4'b0000;
    msticky = 1'b0;
    mcnt    = 2'd0;
  endtask

  // Drive one edge: inputs at negedge, prediction pushed, return 2 time units after posedge.
  task automatic step(input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic clr);
    exp_t x;
    logic hit;
    @(negedge clk);
    en = e; s = sv; r = rv; err_clr = clr;
    hit = e && ((sv & rv) != 4'b0000);
    for (int m = 0; m < 4; m++) begin
      x.q[m]   = model_next(m, mq[m], sv, rv, e);
      x.chg[m] = x.q[m] ^ mq[m];
      mq[m]    = x.q[m];
    end
    x.conflict = hit;
    msticky    = (msticky && !clr) || hit;
    x.sticky   = msticky;
    if (clr)                      mcnt = hit ? 2'd1 : 2'd0;
    else if (hit && mcnt != 2'd3) mcnt = mcnt + 2'd1;
    x.cnt = mcnt;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compares every predicted edge against all four instances.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (q_o[m] !== x.q[m]) begin
          errors++;
          $display("FAIL sb_q mode%0d: got %b expected %b", m, q_o[m], x.q[m]);
        end
        checks++;
        if (qb_o[m] !== ~x.q[m]) begin
          errors++;
          $display("FAIL sb_qb mode%0d: got %b expected %b", m, qb_o[m], ~x.q[m]);
        end
        checks++;
        if (chg_o[m] !== x.chg[m]) begin
          errors++;
          $display("FAIL sb_chg mode%0d: got %b expected %b", m, chg_o[m], x.chg[m]);
        end
        checks++;
        if (conflict_o[m] !== x.conflict || sticky_o[m] !== x.sticky) begin
          errors++;
          $display("FAIL sb_flags mode%0d: got conflict=%b sticky=%b expected conflict=%b sticky=%b",
                   m, conflict_o[m], sticky_o[m], x.conflict, x.sticky);
        end
`ifdef SR_CONFLICT_CNT_EN
        checks++;
        if (cnt_o[m] !== x.cnt) begin
          errors++;
          $display("FAIL sb_cnt mode%0d: got %0d expected %0d", m, cnt_o[m], x.cnt);
        end
`endif
      end
      $display("edge t=%0t en=%b s=%b r=%b clr=%b q0=%b q3=%b conflict=%b sticky=%b",
               $time, en, s, r, err_clr, q_o[0], q_o[3], conflict_o[0], sticky_o[0]);
    end
  end

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q_o[0] !== 4'b0000 || qb_o[0] !== 4'b1111 || chg_o[0] !== 4'b0000 ||
        conflict_o[0] !== 1'b0 || sticky_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got q=%b qb=%b chg=%b c=%b st=%b expected 0000/1111/0000/0/0",
               q_o[0], qb_o[0], chg_o[0], conflict_o[0], sticky_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'b1010, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 1'b0);   // leaves sticky and conflict set
    // asynchronous reset mid-cycle, checked before the next clock edge
    @(negedge clk);
    en = 1'b0; s = '0; r = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q_o[0] !== 4'b0000 || qb_o[0] !== 4'b1111 || chg_o[0] !== 4'b0000 ||
        conflict_o[0] !== 1'b0 || sticky_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got q=%b qb=%b chg=%b c=%b st=%b expected 0000/1111/0000/0/0",
               q_o[0], qb_o[0], chg_o[0], conflict_o[0], sticky_o[0]);
    end
    // held in reset across a clock edge even with requests present
    en = 1'b1; s = 4'b1111; r = 4'b0000;
    @(posedge clk);
    #2;
    checks++;
    if (q_o[1] !== 4'b0000 || qb_o[1] !== 4'b1111) begin
      errors++;
      $display("FAIL reset_hold: got q=%b qb=%b expected 0000/1111", q_o[1], qb_o[1]);
    end
    @(negedge clk);
    en = 1'b0; s = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_set_reset();
    step(1'b1, 4'b0011, 4'b0100, 1'b0);
    checks++;
    if (q_o[0] !== 4'b0011 || chg_o[0] !== 4'b0011) begin
      errors++;
      $display("FAIL set_reset_1: got q=%b chg=%b expected 0011/0011", q_o[0], chg_o[0]);
    end
    step(1'b1, 4'b0000, 4'b0001, 1'b0);
    checks++;
    if (q_o[0] !== 4'b0010 || chg_o[0] !== 4'b0001) begin
      errors++;
      $display("FAIL set_reset_2: got q=%b chg=%b expected 0010/0001", q_o[0], chg_o[0]);
    end
  endtask

  task automatic test_conflict_modes();
    logic [3:0] tog_exp;
    step(1'b1, 4'b0000, 4'b1111, 1'b0);   // all modes start from 0000
    tog_exp = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b1111, 4'b1111, 1'b0);
      tog_exp = ~tog_exp;
      checks++;
      if (q_o[0] !== 4'b0000 || q_o[1] !== 4'b1111 || q_o[2] !== 4'b0000) begin
        errors++;
        $display("FAIL conflict_modes_012 edge%0d: got %b/%b/%b expected 0000/1111/0000",
                 k, q_o[0], q_o[1], q_o[2]);
      end
      checks++;
      if (q_o[3] !== tog_exp || chg_o[3] !== 4'b1111) begin
        errors++;
        $display("FAIL conflict_toggle edge%0d: got q=%b chg=%b expected q=%b chg=1111",
                 k, q_o[3], chg_o[3], tog_exp);
      end
      checks++;
      if (conflict_o[0] !== 1'b1 || sticky_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL conflict_flags edge%0d: got c=%b st=%b expected 1/1",
                 k, conflict_o[0], sticky_o[0]);
      end
    end
  endtask

  task automatic test_disable();
    logic [3:0] q3_before;
    q3_before = q_o[3];
    step(1'b0, 4'b1111, 4'b1111, 1'b0);
    checks++;
    if (q_o[3] !== q3_before || chg_o[3] !== 4'b0000 || conflict_o[3] !== 1'b0 ||
        sticky_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL disable: got q=%b chg=%b c=%b st=%b expected q=%b chg=0000 c=0 st=1",
               q_o[3], chg_o[3], conflict_o[3], sticky_o[3], q3_before);
    end
  endtask

  task automatic test_err_clr();
    step(1'b1, 4'b0001, 4'b0001, 1'b1);
    checks++;
    if (sticky_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_conflict: got sticky=%b expected 1", sticky_o[0]);
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    checks++;
    if (sticky_o[0] !== 1'b0 || conflict_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr: got sticky=%b conflict=%b expected 0/0", sticky_o[0], conflict_o[0]);
    end
  endtask

`ifdef SR_CONFLICT_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0110, 4'b0100, 1'b0);
      checks++;
      if (cnt_o[0] !== exp_seq[k]) begin
        errors++;
        $display("FAIL counter edge%0d: got %0d expected %0d", k, cnt_o[0], exp_seq[k]);
      end
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    checks++;
    if (cnt_o[0] !== 2'd0) begin
      errors++;
      $display("FAIL counter_clr: got %0d expected 0", cnt_o[0]);
    end
    step(1'b1, 4'b1000, 4'b1000, 1'b1);
    checks++;
    if (cnt_o[0] !== 2'd1) begin
      errors++;
      $display("FAIL counter_clr_and_hit: got %0d expected 1", cnt_o[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 4) != 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_conflict_modes();
    test_disable();
    test_err_clr();
`ifdef SR_CONFLICT_CNT_EN
    test_counter();
`endif
    test_random();
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
